// File: rtl/imem_load_controller_pkg.sv
// rtl/imem_load_controller_pkg.sv - shared state encoding and constants for the imem loader
package imem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } imem_state_e;

  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
  localparam int          IMEM_DEPTH = 1024;

  // Word-aligned byte address whose word index falls inside the array.
  function automatic logic word_in_range(input logic [31:0] byte_addr, input int depth);
    return {2'b00, byte_addr[31:2]} < 32'(depth);
  endfunction

endpackage

// File: rtl/imem_load_controller_if.sv
// rtl/imem_load_controller_if.sv - valid/ready program load port
interface imem_ld_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;

  modport master (output ld_valid, ld_addr, ld_data, ld_last, input ld_ready);
  modport slave  (input ld_valid, ld_addr, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/imem_load_controller_ram.sv
// rtl/imem_load_controller_ram.sv - DEPTH x 32 array, one sync write port, one async read port
module imem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_load_controller.sv
// rtl/imem_load_controller.sv - CLEAR/LOAD/RUN sequencing of the instruction memory
module imem_load_controller
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  imem_ld_if.slave     ld,
  input  logic         reload,
  input  logic [31:0]  fetch_addr,
  output logic [31:0]  fetch_rdata,
  output logic         core_rst_n,
  output logic [AW:0]  load_count,
  output logic         load_err,
  output logic         busy
);

  imem_state_e   state_q;
  logic [AW-1:0] clr_ptr_q;
  logic [AW:0]   load_count_q;
  logic          load_err_q;
  logic          core_rst_n_q;

  logic          xfer;
  logic          ld_ok;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic          unused_fetch_lsb;

  assign ld.ld_ready = (state_q == ST_LOAD);
  assign xfer        = ld.ld_valid & ld.ld_ready;
  assign ld_ok       = (ld.ld_addr[1:0] == 2'b00) && word_in_range(ld.ld_addr, DEPTH);

  // Reset never touches the array; the CLEAR pass starts on the first edge after rst drops.
  assign ram_we    = !rst && ((state_q == ST_CLEAR) || (xfer && ld_ok));
  assign ram_waddr = (state_q == ST_CLEAR) ? clr_ptr_q : ld.ld_addr[AW+1:2];
  assign ram_wdata = (state_q == ST_CLEAR) ? NOP_INSN : ld.ld_data;

  imem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (fetch_addr[AW+1:2]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      clr_ptr_q    <= '0;
      load_count_q <= '0;
      load_err_q   <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_ptr_q <= clr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
          if (clr_ptr_q == AW'(DEPTH - 1)) begin
            clr_ptr_q <= '0;
            state_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            if (ld_ok) begin
              load_count_q <= load_count_q + {{AW{1'b0}}, 1'b1};
            end else begin
              load_err_q <= 1'b1;
            end
            if (ld.ld_last) begin
              state_q      <= ST_RUN;
              core_rst_n_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (reload) begin
            state_q      <= ST_CLEAR;
            core_rst_n_q <= 1'b0;
            load_count_q <= '0;
          end
        end
        default: begin
          state_q      <= ST_CLEAR;
          core_rst_n_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    fetch_rdata = 32'h0;
    if (state_q == ST_RUN) begin
      fetch_rdata = word_in_range(fetch_addr, DEPTH) ? ram_rdata : NOP_INSN;
    end
  end

  assign unused_fetch_lsb = ^fetch_addr[1:0];
  assign core_rst_n       = core_rst_n_q;
  assign load_count       = load_count_q;
  assign load_err         = load_err_q;
  assign busy             = (state_q != ST_RUN);

endmodule
